fifo_write_scheduler: RTL and testbench



---
 rtl/fifo_write_scheduler_if.sv | 36 +++
 rtl/fifo_write_scheduler.sv | 58 +++++
 tb/tb_fifo_write_scheduler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fifo_write_scheduler_if.sv
// fifo_write_scheduler_if: producer handshakes, memory write port and write-side status of the FIFO write scheduler
//   req_a_*/req_b_*  valid/data from the producers, ready back to them
//   r_ptr_gray_sync  read pointer (Gray) already synchronized into the write clock domain
//   write_*          write port of fifo_memory
//   w_ptr_gray, full, almost_full, fill_level  write-side status
//   modport slave is the scheduler, modport master is the producer/memory side
interface fifo_write_scheduler_if #(
   parameter int NUM_ADDRESS = 8,
   parameter int DATA_LENGTH = 32
);
   localparam int ADDR_WIDTH = $clog2(NUM_ADDRESS);
   logic                   req_a_valid;
   logic [DATA_LENGTH-1:0] req_a_data;
   logic                   req_a_ready;
   logic                   req_b_valid;
   logic [DATA_LENGTH-1:0] req_b_data;
   logic                   req_b_ready;
   logic [ADDR_WIDTH:0]    r_ptr_gray_sync;
   logic                   write_enable;
   logic [ADDR_WIDTH-1:0]  write_address;
   logic [DATA_LENGTH-1:0] write_data_in;
   logic [ADDR_WIDTH:0]    w_ptr_gray;
   logic                   full;
   logic                   almost_full;
   logic [ADDR_WIDTH:0]    fill_level;
   modport master (
      output req_a_valid, req_a_data, req_b_valid, req_b_data, r_ptr_gray_sync,
      input  req_a_ready, req_b_ready, write_enable, write_address, write_data_in,
             w_ptr_gray, full, almost_full, fill_level
   );
   modport slave (
      input  req_a_valid, req_a_data, req_b_valid, req_b_data, r_ptr_gray_sync,
      output req_a_ready, req_b_ready, write_enable, write_address, write_data_in,
             w_ptr_gray, full, almost_full, fill_level
   );
endinterface

// File: rtl/fifo_write_scheduler.sv
// fifo_write_scheduler: arbitrates two producers onto the fifo_memory write port and tracks write pointer and fill flags
//   w_clk    write-domain clock
//   reset_n  asynchronous active-low reset
//   bus      fifo_write_scheduler_if.slave (producer handshakes, write port, status)
//   Define FIFO_WRITE_FIXED_PRIORITY_EN to make A always win ties instead of round-robin.
module fifo_write_scheduler #(
   parameter int NUM_ADDRESS       = 8,
   parameter int DATA_LENGTH       = 32,
   parameter int ALMOST_FULL_LEVEL = 6
) (
   input logic                  w_clk,
   input logic                  reset_n,
   fifo_write_scheduler_if.slave bus
);
   localparam int AW = $clog2(NUM_ADDRESS);
   localparam logic [AW:0] AF_LEVEL = (AW+1)'(ALMOST_FULL_LEVEL);
   logic [AW:0] w_ptr_bin, next_bin, next_gray, r_bin, fill_next;
   logic        grant_a, grant_b, accept, full_next;
`ifdef FIFO_WRITE_FIXED_PRIORITY_EN
   assign grant_a = bus.req_a_valid;
   assign grant_b = bus.req_b_valid & ~bus.req_a_valid;
`else
   logic last_grant;
   // on a tie the requester that did not win last time is granted
   assign grant_a = bus.req_a_valid & (~bus.req_b_valid | last_grant);
   assign grant_b = bus.req_b_valid & (~bus.req_a_valid | ~last_grant);
   always_ff @(posedge w_clk or negedge reset_n)
      if (!reset_n) last_grant <= 1'b1;
      else if (accept) last_grant <= grant_b;
`endif
   // reset_n gating keeps handshakes and writes quiet while reset is held
   assign bus.req_a_ready   = grant_a & ~bus.full & reset_n;
   assign bus.req_b_ready   = grant_b & ~bus.full & reset_n;
   assign accept            = (grant_a & bus.req_a_valid | grant_b & bus.req_b_valid) & ~bus.full & reset_n;
   assign bus.write_enable  = accept;
   assign bus.write_address = w_ptr_bin[AW-1:0];
   assign bus.write_data_in = grant_b ? bus.req_b_data : bus.req_a_data;
   // Gray to binary: each bit is the XOR of all Gray bits at or above it
   for (genvar i = 0; i <= AW; i++) assign r_bin[i] = ^(bus.r_ptr_gray_sync >> i);
   assign next_bin  = w_ptr_bin + {{AW{1'b0}}, accept};
   assign next_gray = next_bin ^ (next_bin >> 1);
   assign fill_next = next_bin - r_bin;
   assign full_next = next_gray == {~bus.r_ptr_gray_sync[AW:AW-1], bus.r_ptr_gray_sync[AW-2:0]};
   always_ff @(posedge w_clk or negedge reset_n)
      if (!reset_n) begin
         w_ptr_bin       <= '0;
         bus.w_ptr_gray  <= '0;
         bus.full        <= 1'b0;
         bus.almost_full <= 1'b0;
         bus.fill_level  <= '0;
      end else begin
         w_ptr_bin       <= next_bin;
         bus.w_ptr_gray  <= next_gray;
         bus.full        <= full_next;
         bus.almost_full <= fill_next >= AF_LEVEL;
         bus.fill_level  <= fill_next;
      end
endmodule

// File: tb/tb_fifo_write_scheduler.sv
// tb_fifo_write_scheduler: directed table and sequence checks of fifo_write_scheduler
module tb_fifo_write_scheduler;
`ifdef FIFO_WRITE_FIXED_PRIORITY_EN
   localparam bit FIX = 1'b1;
`else
   localparam bit FIX = 1'b0;
`endif
   logic w_clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 w_clk = ~w_clk;
   fifo_write_scheduler_if #(.NUM_ADDRESS(8), .DATA_LENGTH(32)) bus ();
   fifo_write_scheduler #(.NUM_ADDRESS(8), .DATA_LENGTH(32), .ALMOST_FULL_LEVEL(6)) dut (
      .w_clk(w_clk),
      .reset_n(reset_n),
      .bus(bus)
   );
   typedef struct {
      logic rst, av; logic [31:0] ad; logic bv; logic [31:0] bd; logic [3:0] rg;
      logic we; logic [2:0] addr; logic [31:0] wd; logic ar, br;
      logic [3:0] gray; logic full, af; logic [3:0] fill;
   } vec_t;
   vec_t tbl [11];
   int checks = 0;
   int errors = 0;
   function automatic logic [3:0] g4(input logic [3:0] x);
      return x ^ (x >> 1);
   endfunction
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask
   task automatic drive(input logic rst, input logic av, input logic [31:0] ad,
                        input logic bv, input logic [31:0] bd, input logic [3:0] rg);
      @(negedge w_clk);
      reset_n = ~rst;
      bus.req_a_valid = av;
      bus.req_a_data = ad;
      bus.req_b_valid = bv;
      bus.req_b_data = bd;
      bus.r_ptr_gray_sync = rg;
      #1;
   endtask
   // Gray write pointer must move at most one bit between consecutive clock edges
   initial begin
      logic [3:0] prev_gray;
      prev_gray = 4'd0;
      forever begin
         @(posedge w_clk);
         if (!reset_n) prev_gray = 4'd0;
         else begin
            checks++;
            if ($countones(bus.w_ptr_gray ^ prev_gray) > 1) begin
               errors++;
               $display("FAIL gray_step: got %b after %b, required one-bit change", bus.w_ptr_gray, prev_gray);
            end
            prev_gray = bus.w_ptr_gray;
         end
      end
   end
   initial begin
      tbl[0]  = '{1'b0,1'b0,32'h0,1'b0,32'h0,4'd0, 1'b0,3'd0,32'h0,1'b0,1'b0, 4'd0,1'b0,1'b0,4'd0};
      tbl[1]  = '{1'b0,1'b1,32'hA5A5A5A5,1'b0,32'h0,4'd0, 1'b1,3'd0,32'hA5A5A5A5,1'b1,1'b0, 4'd0,1'b0,1'b0,4'd0};
      tbl[2]  = '{1'b0,1'b1,32'hDEADBABE,1'b0,32'h0,4'd0, 1'b1,3'd1,32'hDEADBABE,1'b1,1'b0, 4'd1,1'b0,1'b0,4'd1};
      tbl[3]  = '{1'b0,1'b0,32'h0,1'b0,32'h0,4'd0, 1'b0,3'd2,32'h0,1'b0,1'b0, 4'd3,1'b0,1'b0,4'd2};
      tbl[4]  = '{1'b1,1'b1,32'hAAAA0000,1'b1,32'hBBBB0000,4'd0, 1'b0,3'd0,32'h0,1'b0,1'b0, 4'd0,1'b0,1'b0,4'd0};
      tbl[5]  = '{1'b0,1'b1,32'hAAAA0000,1'b1,32'hBBBB0000,4'd0, 1'b1,3'd0,32'hAAAA0000,1'b1,1'b0, 4'd0,1'b0,1'b0,4'd0};
      tbl[6]  = '{1'b0,1'b1,32'hAAAA0001,1'b1,32'hBBBB0001,4'd0, 1'b1,3'd1,FIX ? 32'hAAAA0001 : 32'hBBBB0001,FIX,!FIX, 4'd1,1'b0,1'b0,4'd1};
      tbl[7]  = '{1'b0,1'b1,32'hAAAA0002,1'b1,32'hBBBB0002,4'd0, 1'b1,3'd2,32'hAAAA0002,1'b1,1'b0, 4'd3,1'b0,1'b0,4'd2};
      tbl[8]  = '{1'b0,1'b1,32'hAAAA0003,1'b1,32'hBBBB0003,4'd0, 1'b1,3'd3,FIX ? 32'hAAAA0003 : 32'hBBBB0003,FIX,!FIX, 4'd2,1'b0,1'b0,4'd3};
      tbl[9]  = '{1'b0,1'b0,32'h0,1'b1,32'hBBBB00FF,4'd0, 1'b1,3'd4,32'hBBBB00FF,1'b0,1'b1, 4'd6,1'b0,1'b0,4'd4};
      tbl[10] = '{1'b0,1'b0,32'h0,1'b0,32'h0,4'd0, 1'b0,3'd5,32'h0,1'b0,1'b0, 4'd7,1'b0,1'b0,4'd5};
      bus.req_a_valid = 1'b0;
      bus.req_a_data = 32'h0;
      bus.req_b_valid = 1'b0;
      bus.req_b_data = 32'h0;
      bus.r_ptr_gray_sync = 4'd0;
      repeat (2) @(negedge w_clk);
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].rst, tbl[i].av, tbl[i].ad, tbl[i].bv, tbl[i].bd, tbl[i].rg);
         chk($sformatf("row%0d_we", i), 32'(bus.write_enable), 32'(tbl[i].we));
         chk($sformatf("row%0d_addr", i), 32'(bus.write_address), 32'(tbl[i].addr));
         if (tbl[i].we) chk($sformatf("row%0d_wdata", i), bus.write_data_in, tbl[i].wd);
         chk($sformatf("row%0d_a_ready", i), 32'(bus.req_a_ready), 32'(tbl[i].ar));
         chk($sformatf("row%0d_b_ready", i), 32'(bus.req_b_ready), 32'(tbl[i].br));
         chk($sformatf("row%0d_gray", i), 32'(bus.w_ptr_gray), 32'(tbl[i].gray));
         chk($sformatf("row%0d_full", i), 32'(bus.full), 32'(tbl[i].full));
         chk($sformatf("row%0d_af", i), 32'(bus.almost_full), 32'(tbl[i].af));
         chk($sformatf("row%0d_fill", i), 32'(bus.fill_level), 32'(tbl[i].fill));
      end
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, 1'b1, 32'hC0000000 + k, 1'b0, 32'h0, 4'd0);
         chk($sformatf("fill%0d_we", k), 32'(bus.write_enable), 32'd1);
         chk($sformatf("fill%0d_addr", k), 32'(bus.write_address), k);
         chk($sformatf("fill%0d_full", k), 32'(bus.full), 32'd0);
         chk($sformatf("fill%0d_af", k), 32'(bus.almost_full), (k >= 6) ? 32'd1 : 32'd0);
         chk($sformatf("fill%0d_level", k), 32'(bus.fill_level), k);
      end
      drive(1'b0, 1'b1, 32'hC0000008, 1'b1, 32'hCB000008, 4'd0);
      chk("full_we", 32'(bus.write_enable), 32'd0);
      chk("full_a_ready", 32'(bus.req_a_ready), 32'd0);
      chk("full_b_ready", 32'(bus.req_b_ready), 32'd0);
      chk("full_flag", 32'(bus.full), 32'd1);
      chk("full_af", 32'(bus.almost_full), 32'd1);
      chk("full_level", 32'(bus.fill_level), 32'd8);
      chk("full_gray", 32'(bus.w_ptr_gray), 32'b1100);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'b0011);
      chk("rd_stale_full", 32'(bus.full), 32'd1);
      drive(1'b0, 1'b1, 32'hD0000000, 1'b0, 32'h0, 4'b0011);
      chk("rd_full", 32'(bus.full), 32'd0);
      chk("rd_level", 32'(bus.fill_level), 32'd6);
      chk("rd_we0", 32'(bus.write_enable), 32'd1);
      chk("rd_addr0", 32'(bus.write_address), 32'd0);
      drive(1'b0, 1'b1, 32'hD0000001, 1'b0, 32'h0, 4'b0011);
      chk("rd_we1", 32'(bus.write_enable), 32'd1);
      chk("rd_addr1", 32'(bus.write_address), 32'd1);
      chk("rd_gray9", 32'(bus.w_ptr_gray), 32'b1101);
      chk("rd_level7", 32'(bus.fill_level), 32'd7);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'b0011);
      chk("rd_gray10", 32'(bus.w_ptr_gray), 32'b1111);
      chk("rd_level8", 32'(bus.fill_level), 32'd8);
      chk("rd_refull", 32'(bus.full), 32'd1);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b1, 32'hF0000000 + i, 1'b0, 32'h0, g4(4'(i)));
         chk($sformatf("wrap%0d_we", i), 32'(bus.write_enable), 32'd1);
         chk($sformatf("wrap%0d_addr", i), 32'(bus.write_address), i % 8);
         chk($sformatf("wrap%0d_gray", i), 32'(bus.w_ptr_gray), 32'(g4(4'(i))));
         chk($sformatf("wrap%0d_full", i), 32'(bus.full), 32'd0);
      end
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'b1000);
      chk("wrap_gray0", 32'(bus.w_ptr_gray), 32'd0);
      chk("wrap_addr0", 32'(bus.write_address), 32'd0);
      chk("wrap_level", 32'(bus.fill_level), 32'd1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 32'hE0000000 + i, 1'b0, 32'h0, 4'b1000);
         chk($sformatf("burst%0d_addr", i), 32'(bus.write_address), i);
      end
      drive(1'b1, 1'b1, 32'hE0000003, 1'b1, 32'hF3000003, 4'b1000);
      chk("rst_we", 32'(bus.write_enable), 32'd0);
      chk("rst_a_ready", 32'(bus.req_a_ready), 32'd0);
      chk("rst_b_ready", 32'(bus.req_b_ready), 32'd0);
      chk("rst_addr", 32'(bus.write_address), 32'd0);
      chk("rst_gray", 32'(bus.w_ptr_gray), 32'd0);
      chk("rst_full", 32'(bus.full), 32'd0);
      chk("rst_af", 32'(bus.almost_full), 32'd0);
      chk("rst_level", 32'(bus.fill_level), 32'd0);
      drive(1'b0, 1'b1, 32'hE0000004, 1'b0, 32'h0, 4'd0);
      chk("post_rst_we", 32'(bus.write_enable), 32'd1);
      chk("post_rst_addr", 32'(bus.write_address), 32'd0);
      chk("post_rst_wdata", bus.write_data_in, 32'hE0000004);
      @(negedge w_clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
